// File: rtl/alu_exec_seq_if.sv
// Operation/result bundle between ID/EX, the execute-stage ALU sequencer and the hazard unit.
interface alu_exec_seq_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_OPCODE   = 6,
  parameter int NB_FUNCTION = 6,
  parameter int NB_SHAMT    = 5,
  parameter int NB_IMM      = 16
);
  logic                   valid_i;
  logic [NB_OPCODE-1:0]   opcode;
  logic [NB_FUNCTION-1:0] funct;
  logic [NB_SHAMT-1:0]    shamt;
  logic [NB_DATA-1:0]     rs_data;
  logic [NB_DATA-1:0]     rt_data;
  logic [NB_IMM-1:0]      imm;
  logic [NB_DATA-1:0]     result;
  logic                   result_valid;
  logic                   illegal;
  logic                   busy;
  logic [NB_DATA-1:0]     hi_o;
  logic [NB_DATA-1:0]     lo_o;

  modport slave (
    input  valid_i, opcode, funct, shamt, rs_data, rt_data, imm,
    output result, result_valid, illegal, busy, hi_o, lo_o
  );

  modport master (
    output valid_i, opcode, funct, shamt, rs_data, rt_data, imm,
    input  result, result_valid, illegal, busy, hi_o, lo_o
  );
endinterface

// File: rtl/alu_exec_seq.sv
// EX-stage ALU: single-cycle ops with a registered result, plus an iterative
// shift-add multiplier / restoring divider that writes HI/LO and stalls via busy.
module alu_exec_seq #(
  parameter int NB_DATA     = 32,
  parameter int NB_OPCODE   = 6,
  parameter int NB_FUNCTION = 6,
  parameter int NB_SHAMT    = 5,
  parameter int NB_IMM      = 16
) (
  input  logic          clock,
  input  logic          reset,
  alu_exec_seq_if.slave bus
);
  localparam int ND = NB_DATA;
  localparam int CW = NB_SHAMT + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NB_DATA);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'b000000;
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = 6'b001000;
  localparam logic [NB_OPCODE-1:0] OP_ADDIU = 6'b001001;
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = 6'b001010;
  localparam logic [NB_OPCODE-1:0] OP_SLTIU = 6'b001011;
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = 6'b001100;
  localparam logic [NB_OPCODE-1:0] OP_ORI   = 6'b001101;
  localparam logic [NB_OPCODE-1:0] OP_XORI  = 6'b001110;
  localparam logic [NB_OPCODE-1:0] OP_LUI   = 6'b001111;
  localparam logic [NB_OPCODE-1:0] OP_LB    = 6'b100000;
  localparam logic [NB_OPCODE-1:0] OP_LH    = 6'b100001;
  localparam logic [NB_OPCODE-1:0] OP_LW    = 6'b100011;
  localparam logic [NB_OPCODE-1:0] OP_LBU   = 6'b100100;
  localparam logic [NB_OPCODE-1:0] OP_LHU   = 6'b100101;
  localparam logic [NB_OPCODE-1:0] OP_LWU   = 6'b100111;
  localparam logic [NB_OPCODE-1:0] OP_SB    = 6'b101000;
  localparam logic [NB_OPCODE-1:0] OP_SH    = 6'b101001;
  localparam logic [NB_OPCODE-1:0] OP_SW    = 6'b101011;

  localparam logic [NB_FUNCTION-1:0] F_SLL   = 6'b000000;
  localparam logic [NB_FUNCTION-1:0] F_SRL   = 6'b000010;
  localparam logic [NB_FUNCTION-1:0] F_SRA   = 6'b000011;
  localparam logic [NB_FUNCTION-1:0] F_SLLV  = 6'b000100;
  localparam logic [NB_FUNCTION-1:0] F_SRLV  = 6'b000110;
  localparam logic [NB_FUNCTION-1:0] F_SRAV  = 6'b000111;
  localparam logic [NB_FUNCTION-1:0] F_MFHI  = 6'b010000;
  localparam logic [NB_FUNCTION-1:0] F_MFLO  = 6'b010010;
  localparam logic [NB_FUNCTION-1:0] F_MULT  = 6'b011000;
  localparam logic [NB_FUNCTION-1:0] F_MULTU = 6'b011001;
  localparam logic [NB_FUNCTION-1:0] F_DIV   = 6'b011010;
  localparam logic [NB_FUNCTION-1:0] F_DIVU  = 6'b011011;
  localparam logic [NB_FUNCTION-1:0] F_ADD   = 6'b100000;
  localparam logic [NB_FUNCTION-1:0] F_ADDU  = 6'b100001;
  localparam logic [NB_FUNCTION-1:0] F_SUB   = 6'b100010;
  localparam logic [NB_FUNCTION-1:0] F_SUBU  = 6'b100011;
  localparam logic [NB_FUNCTION-1:0] F_AND   = 6'b100100;
  localparam logic [NB_FUNCTION-1:0] F_OR    = 6'b100101;
  localparam logic [NB_FUNCTION-1:0] F_XOR   = 6'b100110;
  localparam logic [NB_FUNCTION-1:0] F_NOR   = 6'b100111;
  localparam logic [NB_FUNCTION-1:0] F_SLT   = 6'b101010;
  localparam logic [NB_FUNCTION-1:0] F_SLTU  = 6'b101011;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*ND-1:0]   acc_q, acc_d;
  logic [ND-1:0]     opnd_q, opnd_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic [ND-1:0]     hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic              rvalid_q, rvalid_d, illegal_q, illegal_d;

  logic              accept_s, legal_s, mul_op_s, div_op_s, sgn_op_s;
  logic [ND-1:0]     alu_res_s, imm_sx_s, imm_zx_s, mag_a_s, mag_b_s;
  logic [ND:0]       mul_sum_s, rem_sh_s, div_diff_s;
  logic [ND-1:0]     rem_new_s;
  logic              div_ge_s;
  logic [2*ND-1:0]   mul_next_s, div_next_s, mul_fix_s;
  logic [ND-1:0]     quo_fix_s, rem_fix_s;

  assign accept_s = bus.valid_i && (state_q == S_IDLE);
  assign imm_sx_s = {{(ND-NB_IMM){bus.imm[NB_IMM-1]}}, bus.imm};
  assign imm_zx_s = {{(ND-NB_IMM){1'b0}}, bus.imm};
  assign mag_a_s  = (sgn_op_s && bus.rs_data[ND-1]) ? -bus.rs_data : bus.rs_data;
  assign mag_b_s  = (sgn_op_s && bus.rt_data[ND-1]) ? -bus.rt_data : bus.rt_data;

  // One shift-add step: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum_s  = {1'b0, acc_q[2*ND-1:ND]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next_s = {mul_sum_s, acc_q[ND-1:1]};
  assign mul_fix_s  = neg_q ? -mul_next_s : mul_next_s;

  // One restoring-divide step: acc holds {partial remainder, dividend/quotient}.
  assign rem_sh_s   = {acc_q[2*ND-1:ND], acc_q[ND-1]};
  assign div_diff_s = rem_sh_s - {1'b0, opnd_q};
  assign div_ge_s   = (rem_sh_s >= {1'b0, opnd_q});
  assign rem_new_s  = div_ge_s ? div_diff_s[ND-1:0] : rem_sh_s[ND-1:0];
  assign div_next_s = {rem_new_s, acc_q[ND-2:0], div_ge_s};
  assign quo_fix_s  = div0_q ? {ND{1'b1}} : (neg_q ? -div_next_s[ND-1:0] : div_next_s[ND-1:0]);
  assign rem_fix_s  = rneg_q ? -div_next_s[2*ND-1:ND] : div_next_s[2*ND-1:ND];

  // Opcode/funct decode and single-cycle result.
  always_comb begin
    alu_res_s = '0;
    legal_s   = 1'b1;
    mul_op_s  = 1'b0;
    div_op_s  = 1'b0;
    sgn_op_s  = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          F_SLL:          alu_res_s = bus.rt_data << bus.shamt;
          F_SRL:          alu_res_s = bus.rt_data >> bus.shamt;
          F_SRA:          alu_res_s = $signed(bus.rt_data) >>> bus.shamt;
          F_SLLV:         alu_res_s = bus.rt_data << bus.rs_data[NB_SHAMT-1:0];
          F_SRLV:         alu_res_s = bus.rt_data >> bus.rs_data[NB_SHAMT-1:0];
          F_SRAV:         alu_res_s = $signed(bus.rt_data) >>> bus.rs_data[NB_SHAMT-1:0];
          F_MFHI:         alu_res_s = hi_q;
          F_MFLO:         alu_res_s = lo_q;
          F_ADD, F_ADDU:  alu_res_s = bus.rs_data + bus.rt_data;
          F_SUB, F_SUBU:  alu_res_s = bus.rs_data - bus.rt_data;
          F_AND:          alu_res_s = bus.rs_data & bus.rt_data;
          F_OR:           alu_res_s = bus.rs_data | bus.rt_data;
          F_XOR:          alu_res_s = bus.rs_data ^ bus.rt_data;
          F_NOR:          alu_res_s = ~(bus.rs_data | bus.rt_data);
          F_SLT:   alu_res_s = {{(ND-1){1'b0}}, ($signed(bus.rs_data) < $signed(bus.rt_data))};
          F_SLTU:  alu_res_s = {{(ND-1){1'b0}}, (bus.rs_data < bus.rt_data)};
          F_MULT:  begin mul_op_s = 1'b1; sgn_op_s = 1'b1; end
          F_MULTU: mul_op_s = 1'b1;
          F_DIV:   begin div_op_s = 1'b1; sgn_op_s = 1'b1; end
          F_DIVU:  div_op_s = 1'b1;
          default: legal_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW:
        alu_res_s = bus.rs_data + imm_sx_s;
      OP_SLTI:  alu_res_s = {{(ND-1){1'b0}}, ($signed(bus.rs_data) < $signed(imm_sx_s))};
      OP_SLTIU: alu_res_s = {{(ND-1){1'b0}}, (bus.rs_data < imm_sx_s)};
      OP_ANDI:  alu_res_s = bus.rs_data & imm_zx_s;
      OP_ORI:   alu_res_s = bus.rs_data | imm_zx_s;
      OP_XORI:  alu_res_s = bus.rs_data ^ imm_zx_s;
      OP_LUI:   alu_res_s = {bus.imm, {(ND-NB_IMM){1'b0}}};
      default:  legal_s = 1'b0;
    endcase
  end

  // Next-state for sequencer, HI/LO and result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    rvalid_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && mul_op_s) begin
          state_d = S_MUL;
          cnt_d   = CNT_LOAD;
          acc_d   = {{ND{1'b0}}, mag_b_s};
          opnd_d  = mag_a_s;
          neg_d   = sgn_op_s && (bus.rs_data[ND-1] ^ bus.rt_data[ND-1]);
        end else if (accept_s && div_op_s) begin
          state_d = S_DIV;
          cnt_d   = CNT_LOAD;
          acc_d   = {{ND{1'b0}}, mag_a_s};
          opnd_d  = mag_b_s;
          neg_d   = sgn_op_s && (bus.rs_data[ND-1] ^ bus.rt_data[ND-1]);
          rneg_d  = sgn_op_s && bus.rs_data[ND-1];
          div0_d  = (bus.rt_data == '0);
        end else if (accept_s) begin
          result_d  = alu_res_s;
          rvalid_d  = 1'b1;
          illegal_d = !legal_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_LAST;
        acc_d = (state_q == S_MUL) ? mul_next_s : div_next_s;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          if (state_q == S_MUL) begin
            hi_d = mul_fix_s[2*ND-1:ND];
            lo_d = mul_fix_s[ND-1:0];
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply/divide in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      rvalid_q  <= rvalid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = rvalid_q;
  assign bus.illegal      = illegal_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Parametrised execute-stage unit that decodes opcode/funct and executes the operation in one block. Single-cycle ALU operations return a registered result; MULT/MULTU/DIV/DIVU run on an iterative sequencer that writes internal HI/LO registers. MFHI/MFLO read HI/LO. Sits in the EX stage between ID/EX and EX/MEM, and exports `busy` to the hazard unit as a stall request.

## Interface

**Parameters**
- `NB_DATA`, 32: datapath width; must be even and ≥ 8.
- `NB_OPCODE`, 6: opcode width.
- `NB_FUNCTION`, 6: funct width.
- `NB_SHAMT`, 5: shift-amount width; must equal clog2(`NB_DATA`).
- `NB_IMM`, 16: immediate width.

**Ports**
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_i` in 1: an operation is presented this cycle.
- `opcode` in `NB_OPCODE`: instruction opcode.
- `funct` in `NB_FUNCTION`: R-type funct.
- `shamt` in `NB_SHAMT`: shift amount for SLL/SRL/SRA.
- `rs_data` in `NB_DATA`: operand A.
- `rt_data` in `NB_DATA`: operand B.
- `imm` in `NB_IMM`: raw immediate; extension is done internally.
- `result` out `NB_DATA`: registered result.
- `result_valid` out 1: one-cycle pulse when `result` is new.
- `illegal` out 1: one-cycle pulse on an unrecognised opcode/funct.
- `busy` out 1: multiply/divide in progress; new operations are refused.
- `hi_o` out `NB_DATA`: HI register (debug).
- `lo_o` out `NB_DATA`: LO register (debug).

## Operation

**Acceptance**
- An operation is accepted when `valid_i && !busy`.
- `valid_i` while `busy` is ignored with no side effects; upstream holds the instruction.

**Single-cycle, R-type (opcode 000000)**
- SLL 000000, SRL 000010, SRA 000011 use `shamt`.
- SLLV 000100, SRLV 000110, SRAV 000111 use `rs_data[NB_SHAMT-1:0]`; the shifted operand is `rt_data`.
- ADD 100000 and ADDU 100001: add, wrap, no trap.
- SUB 100010 and SUBU 100011: subtract, wrap, no trap.
- AND 100100, OR 100101, XOR 100110, NOR 100111.
- SLT 101010: signed compare, result 1/0. SLTU 101011: unsigned compare, result 1/0.
- MFHI 010000 returns HI. MFLO 010010 returns LO.

**Single-cycle, I-type**
- Sign-extended immediate: ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011 (sign-extend, then unsigned compare).
- Zero-extended immediate: ANDI 001100, ORI 001101, XORI 001110.
- LUI 001111: `imm` placed in the upper bits, lower `NB_DATA-NB_IMM` bits zero.
- Loads/stores compute `rs_data + sext(imm)`: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LWU 100111, SB 101000, SH 101001, SW 101011.

**Unrecognised opcode/funct**
- `result` = 0; `result_valid` and `illegal` both pulse.

**Multi-cycle (R-type funct)**
- Opcodes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. No `result_valid` pulse; only HI/LO are written.
- Signed operations run on magnitudes and correct the sign at the end.
- Multiply: shift-add, one partial product per cycle. `{HI,LO}` = 2·`NB_DATA`-bit product.
- Divide: restoring, one quotient bit per cycle. LO = quotient, HI = remainder.
- Signed divide signs: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
- Divide by zero: LO = all ones, HI = `rs_data`, same latency.
- DIV most-negative / −1: LO = most-negative, HI = 0.

**FSM states**
- IDLE → MUL on accepted MULT/MULTU; counter loaded with `NB_DATA`.
- IDLE → DIV on accepted DIV/DIVU; counter loaded with `NB_DATA`.
- MUL/DIV: counter decrements each cycle. At the count-1 edge, HI/LO are written after sign fix and the FSM returns to IDLE.
- `busy` = (state ≠ IDLE), decoded combinationally from state.

## Timing

- **Reset** (asynchronous, immediate): `result`, `hi_o`, `lo_o` = 0; `result_valid`, `illegal`, `busy` = 0; state IDLE; counter 0. Reset during MUL/DIV aborts the operation and HI/LO read 0 afterwards.
- **Single-cycle ops:** accepted at edge T0; `result`/`result_valid` valid in the cycle after T0 (latency 1). Back-to-back every cycle is allowed. `result` holds its value between pulses.
- **Multi-cycle ops:** accepted at T0; `busy` high for exactly `NB_DATA` cycles (T0+1 … T0+`NB_DATA`). HI/LO are updated at edge T0+`NB_DATA`.
- First acceptance after a multi-cycle op is at T0+`NB_DATA`; an MFHI/MFLO there returns the new value one cycle later.
- During `busy`, `result`/`result_valid` from a prior single-cycle op behave normally: the pulse still occurs the cycle after T0.
- Operand registers are captured at acceptance, so input changes during `busy` have no effect.

## Test plan

- **Single-cycle ops.** Each is valid one cycle after acceptance, with `result_valid` pulsing each cycle:
  - SUBU 5−7 → 0xFFFFFFFE
  - SRA 0x80000000 by 4 → 0xF8000000
  - SLTIU rs=1, imm=0xFFFF → 1
  - ANDI 0xFFFFFFFF, 0x8000 → 0x00008000
  - LUI 0x1234 → 0x12340000
- **MULT** 0xFFFFFFFE × 3 → `busy` high 32 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO issued on the first non-busy cycle returns 0xFFFFFFFA.
- **Divide:**
  - DIVU 100/7 → LO=14, HI=2.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- **Interlock.** ADDU asserted on `valid_i` during cycles 5–10 of a MULT → ignored: no `result_valid`, HI/LO unaffected. The same ADDU held until `busy` falls is accepted exactly once.
- **Reset mid-operation.** `reset` pulsed at cycle 10 of a DIV → `busy` drops immediately, HI/LO=0; MFHI afterwards returns 0.
- **Illegal.** opcode 111111 → `result`=0; `illegal` and `result_valid` pulse for one cycle.
